// File: rtl/aes256_reg_sequencer.sv
// Register-write front end for an AES-256 core: assembles key/data words, runs one
// valid/ready request per start command and holds the captured result for read-back.
module aes256_reg_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic         ACLK,
    input  logic         ARESET,
    input  logic         wr_en,
    input  logic [3:0]   wr_idx,
    input  logic [31:0]  wr_data,
    input  logic         rd_en,
    input  logic [2:0]   rd_idx,
    output logic [31:0]  rd_data,
    output logic         rd_valid,
    output logic         core_valid,
    input  logic         core_ready,
    output logic [255:0] core_key,
    output logic [127:0] core_din,
    input  logic [127:0] core_dout,
    input  logic         core_dout_valid,
    output logic         irq
);

    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    // state  | meaning
    // S_IDLE | no operation launched since reset/clear
    // S_REQ  | core_valid high, waiting for core_ready
    // S_WAIT | operands accepted, waiting for result or timeout
    // S_DONE | result captured or timed out, flags readable
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t state, state_nx;

    logic [255:0]      key_q;
    logic [127:0]      din_q;
    logic [127:0]      result_q;
    logic              done_q, timeout_q, wr_err_q;
    logic [CNT_W-1:0]  op_cnt;
    logic [TO_W-1:0]   to_cnt;

    logic        busy, ctl_wr, start, clear, opnd_wr;
    logic        capture, tmo, clr_run, clr_err, set_err;
    logic [31:0] rd_word;

    assign busy     = (state == S_REQ) || (state == S_WAIT);
    assign ctl_wr   = wr_en && (wr_idx == 4'd12);
    assign start    = ctl_wr && wr_data[0];
    assign clear    = ctl_wr && wr_data[1];
    assign opnd_wr  = wr_en && (wr_idx < 4'd12);

    assign core_valid = (state == S_REQ);
    assign core_key   = key_q;
    assign core_din   = din_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        tmo      = 1'b0;
        clr_run  = 1'b0;
        clr_err  = 1'b0;
        set_err  = busy && (opnd_wr || start);
        case (state)
            S_IDLE, S_DONE: begin
                // start has priority over clear when both bits are written
                if (start) begin
                    state_nx = S_REQ;
                    clr_run  = 1'b1;
                end else if (clear) begin
                    state_nx = S_IDLE;
                    clr_run  = 1'b1;
                    clr_err  = 1'b1;
                end
            end
            S_REQ: begin
                if (core_ready) begin
                    if (core_dout_valid) begin
                        capture  = 1'b1;
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (core_dout_valid) begin
                    capture  = 1'b1;
                    state_nx = S_DONE;
                end else if (TO_EN && (to_cnt == TO_LAST)) begin
                    tmo      = 1'b1;
                    state_nx = S_DONE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        rd_word = 32'd0;
        case (rd_idx)
            3'd0: rd_word = result_q[127:96];
            3'd1: rd_word = result_q[95:64];
            3'd2: rd_word = result_q[63:32];
            3'd3: rd_word = result_q[31:0];
            3'd4: rd_word = {16'(op_cnt), 12'd0, timeout_q, wr_err_q, done_q, busy};
            default: rd_word = 32'd0;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            key_q     <= '0;
            din_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            wr_err_q  <= 1'b0;
            op_cnt    <= '0;
            to_cnt    <= '0;
            irq       <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
        end else begin
            // operand registers are frozen while a request is outstanding
            if (opnd_wr && !busy) begin
                for (int i = 0; i < 8; i++)
                    if (wr_idx == 4'(i)) key_q[32*(7-i) +: 32] <= wr_data;
                for (int i = 0; i < 4; i++)
                    if (wr_idx == 4'(8 + i)) din_q[32*(3-i) +: 32] <= wr_data;
            end

            if (clr_err)      wr_err_q <= 1'b0;
            else if (set_err) wr_err_q <= 1'b1;

            if (clr_run)      done_q <= 1'b0;
            else if (capture) done_q <= 1'b1;

            if (clr_run)  timeout_q <= 1'b0;
            else if (tmo) timeout_q <= 1'b1;

            if (capture) begin
                result_q <= core_dout;
                op_cnt   <= op_cnt + 1'b1;
            end

            to_cnt   <= (state == S_WAIT) ? to_cnt + 1'b1 : '0;
            irq      <= capture || tmo;
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_word;
        end
    end

endmodule

// File: tb/tb_aes256_reg_sequencer.sv
// Scoreboarded bench for aes256_reg_sequencer: directed vectors plus randomized operations
// checked against a word-level behavioural model.
module tb_aes256_reg_sequencer;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic         wr_en;
    logic [3:0]   wr_idx;
    logic [31:0]  wr_data;
    logic         rd_en;
    logic [2:0]   rd_idx;
    logic [31:0]  rd_data;
    logic         rd_valid;
    logic         core_valid;
    logic         core_ready;
    logic [255:0] core_key;
    logic [127:0] core_din;
    logic [127:0] core_dout;
    logic         core_dout_valid;
    logic         irq;

    always #5 ACLK = ~ACLK;

    aes256_reg_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid),
        .core_valid(core_valid), .core_ready(core_ready),
        .core_key(core_key), .core_din(core_din),
        .core_dout(core_dout), .core_dout_valid(core_dout_valid),
        .irq(irq)
    );

    int tests = 0;
    int fails = 0;
    int irq_seen = 0;
    int irq_exp = 0;
    logic [31:0] exp_q[$];

    // behavioural model: mode 0 = idle, 1 = operation in flight, 2 = finished
    logic [31:0]  m_key[8];
    logic [31:0]  m_din[4];
    logic [127:0] m_res;
    int           m_mode;
    bit           m_done, m_to, m_err;
    int           m_cnt;

    task automatic check(string name, logic [255:0] act, logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] m_key_vec();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = m_key[i];
        return r;
    endfunction

    function automatic logic [127:0] m_din_vec();
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[127-32*i -: 32] = m_din[i];
        return r;
    endfunction

    function automatic logic [31:0] m_read(int idx);
        if (idx < 4) return m_res[127-32*idx -: 32];
        if (idx == 4) return {m_cnt[15:0], 12'd0, m_to, m_err, m_done, (m_mode == 1)};
        return 32'd0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_key[i] = 32'd0;
        for (int i = 0; i < 4; i++) m_din[i] = 32'd0;
        m_res = '0; m_mode = 0; m_done = 0; m_to = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic m_capture(logic [127:0] v);
        m_res = v; m_done = 1; m_mode = 2; m_cnt = (m_cnt + 1) % 65536; irq_exp++;
    endtask

    // monitor: pops expected read data whenever the DUT presents a read response
    initial begin
        forever begin
            @(negedge ACLK);
            if (irq) irq_seen++;
            if (rd_valid) begin
                if (exp_q.size() == 0) check("rd_unexpected", 256'(exp_q.size()), 256'd1);
                else check("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(negedge ACLK);
    endtask

    task automatic wr(int idx, logic [31:0] d);
        wr_en = 1'b1; wr_idx = 4'(idx); wr_data = d;
        if (idx < 8) begin
            if (m_mode == 1) m_err = 1; else m_key[idx] = d;
        end else if (idx < 12) begin
            if (m_mode == 1) m_err = 1; else m_din[idx-8] = d;
        end else if (idx == 12) begin
            if (d[0]) begin
                if (m_mode == 1) m_err = 1;
                else begin m_mode = 1; m_done = 0; m_to = 0; end
            end else if (d[1] && m_mode != 1) begin
                m_mode = 0; m_done = 0; m_to = 0; m_err = 0;
            end
        end
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(int idx);
        rd_en = 1'b1; rd_idx = 3'(idx);
        exp_q.push_back(m_read(idx));
        tick();
        rd_en = 1'b0;
    endtask

    task automatic rd_all();
        for (int i = 0; i < 8; i++) rd(i);
        tick();
    endtask

    task automatic start_op(bit with_clear);
        wr(12, {30'd0, with_clear, 1'b1});
        check("core_valid_rise", core_valid, 1'b1);
        check("core_key", core_key, m_key_vec());
        check("core_din", core_din, m_din_vec());
    endtask

    task automatic handshake(int bp);
        for (int i = 0; i < bp; i++) begin
            tick();
            check("bp_valid_held", core_valid, 1'b1);
            check("bp_key_stable", core_key, m_key_vec());
            check("bp_din_stable", core_din, m_din_vec());
        end
        core_ready = 1'b1;
        tick();
        core_ready = 1'b0;
        check("valid_drop", core_valid, 1'b0);
    endtask

    task automatic respond(int lat, logic [127:0] v, bit rd_same);
        int idx;
        repeat (lat) tick();
        core_dout_valid = 1'b1; core_dout = v;
        if (rd_same) begin
            idx = $urandom_range(0, 3);
            rd_en = 1'b1; rd_idx = 3'(idx);
            exp_q.push_back(m_read(idx));
        end
        m_capture(v);
        tick();
        core_dout_valid = 1'b0; rd_en = 1'b0;
        check("irq_pulse", irq, 1'b1);
        tick();
        check("irq_single", irq, 1'b0);
        check("irq_count", 256'(irq_seen), 256'(irq_exp));
    endtask

    initial begin
        int k, idx;
        logic [127:0] v;
        ARESET = 1'b1; wr_en = 0; wr_idx = 0; wr_data = 0; rd_en = 0; rd_idx = 0;
        core_ready = 0; core_dout = '0; core_dout_valid = 0;
        m_reset();
        tick(); tick();
        ARESET = 1'b0;
        tick();
        check("rst_core_valid", core_valid, 1'b0);
        check("rst_key", core_key, 256'd0);
        check("rst_din", core_din, 128'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_irq", irq, 1'b0);
        rd_all();

        // FIPS-197 AES-256 vector
        for (int i = 0; i < 8; i++)
            wr(i, {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)});
        wr(8, 32'h00112233); wr(9, 32'h44556677); wr(10, 32'h8899aabb); wr(11, 32'hccddeeff);
        start_op(0);
        check("fips_key", core_key,
              256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        check("fips_din", core_din, 128'h00112233445566778899aabbccddeeff);
        handshake(0);
        respond(13, 128'h8ea2b7ca516745bfeafc49904b496089, 0);
        rd_all();

        // backpressure, read racing the capture
        start_op(0);
        handshake(5);
        respond(3, {$urandom, $urandom, $urandom, $urandom}, 1);
        rd_all();

        // writes and start rejected while busy
        start_op(0);
        handshake(0);
        wr(8, $urandom);
        check("busy_din_kept", core_din, m_din_vec());
        wr(12, 32'd1);
        respond(5, {$urandom, $urandom, $urandom, $urandom}, 0);
        rd(4);
        wr(12, 32'd2);
        rd(4);
        tick();

        // timeout with the core silent
        start_op(0);
        handshake(2);
        k = 1;
        while (k <= 40) begin
            tick();
            if (irq) break;
            k++;
        end
        check("timeout_cycles", 256'(k), 256'd16);
        m_mode = 2; m_to = 1; irq_exp++;
        tick();
        check("timeout_irq_single", irq, 1'b0);
        rd_all();

        // ready and result in the same cycle
        start_op(0);
        core_ready = 1'b1; core_dout_valid = 1'b1;
        v = {$urandom, $urandom, $urandom, $urandom};
        core_dout = v;
        m_capture(v);
        tick();
        core_ready = 1'b0; core_dout_valid = 1'b0;
        check("same_cycle_valid", core_valid, 1'b0);
        check("same_cycle_irq", irq, 1'b1);
        rd(4);
        rd_all();

        // randomized operations
        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 4)) begin
                idx = $urandom_range(0, 14);
                if (idx >= 12) idx++;
                wr(idx, $urandom);
            end
            if ($urandom_range(0, 3) == 0) wr(12, 32'd2);
            start_op(1'($urandom_range(0, 1)));
            handshake($urandom_range(0, 5));
            respond($urandom_range(0, 15), {$urandom, $urandom, $urandom, $urandom},
                    1'($urandom_range(0, 1)));
            repeat (3) rd($urandom_range(0, 7));
            tick();
        end

        // reset during WAIT, then a late result
        start_op(0);
        handshake(0);
        tick(); tick();
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        m_reset();
        core_dout_valid = 1'b1; core_dout = {$urandom, $urandom, $urandom, $urandom};
        tick();
        core_dout_valid = 1'b0;
        check("late_core_valid", core_valid, 1'b0);
        check("late_key", core_key, 256'd0);
        check("late_din", core_din, 128'd0);
        check("late_irq", irq, 1'b0);
        check("late_rd_data", rd_data, 32'd0);
        check("late_rd_valid", rd_valid, 1'b0);
        rd_all();

        tick(); tick();
        check("rd_drain", 256'(exp_q.size()), 256'd0);
        check("irq_total", 256'(irq_seen), 256'(irq_exp));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
